// File: rtl/pc_unit.sv
// Program-counter unit for the fetch stage: boot delay, sequential advance,
// redirect/trap entry, halt/resume, misaligned-redirect detection, fire counter.
module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              IALIGN       = 32,
  parameter int              BOOT_CYCLES  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] fetch_pc,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_base,
  input  logic            halt_req,
  input  logic            resume,
  output logic            misalign_err,
  output logic [XLEN-1:0] misalign_addr,
  output logic [1:0]      state,
  output logic [31:0]     fetch_count
);

  localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);
  localparam logic [XLEN-1:0] AMASK =
    (IALIGN == 16) ? XLEN'(1) : XLEN'(3);

  typedef enum logic [1:0] {
    S_BOOT = 2'b00,
    S_RUN  = 2'b01,
    S_HALT = 2'b10,
    S_ILL  = 2'b11
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [BW-1:0]   boot_q, boot_d;
  logic [31:0]     cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] addr_q, addr_d;

  logic [XLEN-1:0] trap_tgt;
  logic            redir_mis;
  logic            fire;

  assign trap_tgt    = trap_base & ~AMASK;
  assign redir_mis   = |(redirect_pc & AMASK);
  assign fetch_valid = (state_q == S_RUN) & ~stall;
  assign fire        = fetch_valid & fetch_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_VECTOR;
      boot_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      boot_q  <= boot_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    boot_d  = boot_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    addr_d  = addr_q;

    if (fire && (cnt_q != 32'hFFFF_FFFF))
      cnt_d = cnt_q + 32'd1;

    unique case (state_q)
      S_BOOT: begin
        if (trap_valid) begin
          pc_d    = trap_tgt;
          state_d = S_RUN;
        end else if (boot_q == BOOT_LAST) begin
          state_d = S_RUN;
        end else begin
          boot_d = boot_q + BW'(1);
        end
      end
      S_RUN: begin
        // halt still lets this cycle's PC update land
        if (halt_req)
          state_d = S_HALT;
        if (trap_valid) begin
          pc_d = trap_tgt;
        end else if (redirect_valid && !redir_mis) begin
          pc_d = redirect_pc;
        end else if (redirect_valid) begin
          pc_d   = trap_tgt;
          err_d  = 1'b1;
          addr_d = redirect_pc;
        end else if (fire) begin
          pc_d = pc_q + XLEN'(4);
        end
      end
      S_HALT: begin
        if (trap_valid) begin
          pc_d    = trap_tgt;
          state_d = S_RUN;
        end else if (resume) begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_BOOT;
        boot_d  = '0;
      end
    endcase
  end

  assign fetch_pc      = pc_q;
  assign misalign_err  = err_q;
  assign misalign_addr = addr_q;
  assign state         = state_q;
  assign fetch_count   = cnt_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed vector table, hand sequences
// for halt/wrap/saturation/reset, then random stimulus against a model.
module tb_pc_unit;

  localparam logic [31:0] RV = 32'h100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        stall, ready, redir, trap, halt, resume;
  logic [31:0] rpc, tbase;

  logic [31:0] pc, mad, cnt;
  logic        val, err;
  logic [1:0]  st;
  logic [31:0] pc16, mad16, cnt16;
  logic        val16, err16;
  logic [1:0]  st16;

  pc_unit #(
    .XLEN(32), .RESET_VECTOR(RV), .IALIGN(32), .BOOT_CYCLES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_pc(pc), .fetch_valid(val), .fetch_ready(ready),
    .stall(stall), .redirect_valid(redir), .redirect_pc(rpc),
    .trap_valid(trap), .trap_base(tbase),
    .halt_req(halt), .resume(resume),
    .misalign_err(err), .misalign_addr(mad),
    .state(st), .fetch_count(cnt)
  );

  pc_unit #(
    .XLEN(32), .RESET_VECTOR(RV), .IALIGN(16), .BOOT_CYCLES(2)
  ) dut16 (
    .clk(clk), .rst_n(rst_n),
    .fetch_pc(pc16), .fetch_valid(val16), .fetch_ready(ready),
    .stall(stall), .redirect_valid(redir), .redirect_pc(rpc),
    .trap_valid(trap), .trap_base(tbase),
    .halt_req(halt), .resume(resume),
    .misalign_err(err16), .misalign_addr(mad16),
    .state(st16), .fetch_count(cnt16)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: 0 boot, 1 run, 2 halted
  int          m_state;
  int          m_boot;
  longint      m_pc;
  longint      m_cnt;
  bit          m_err;
  logic [31:0] m_addr;

  task automatic model_reset();
    m_state = 0;
    m_boot  = 0;
    m_pc    = RV;
    m_cnt   = 0;
    m_err   = 0;
    m_addr  = 0;
  endtask

  function automatic longint aligned(logic [31:0] a);
    return (longint'(a) / 4) * 4;
  endfunction

  task automatic model_step();
    bit fire;
    fire  = (m_state == 1) && !stall && ready;
    m_err = 0;
    if (m_state == 0) begin
      if (trap) begin
        m_pc    = aligned(tbase);
        m_state = 1;
      end else begin
        m_boot++;
        if (m_boot >= 2) m_state = 1;
      end
    end else if (m_state == 1) begin
      if (trap) m_pc = aligned(tbase);
      else if (redir && (rpc % 4 == 0)) m_pc = rpc;
      else if (redir) begin
        m_pc   = aligned(tbase);
        m_err  = 1;
        m_addr = rpc;
      end else if (fire) m_pc = (m_pc + 4) % (64'd1 << 32);
      if (fire && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      if (halt) m_state = 2;
    end else begin
      if (trap) begin
        m_pc    = aligned(tbase);
        m_state = 1;
      end else if (resume) m_state = 1;
    end
  endtask

  task automatic check_model();
    chk("pc", pc, m_pc[31:0]);
    chk("valid", {31'b0, val}, {31'b0, (m_state == 1) && !stall});
    chk("state", {30'b0, st}, m_state);
    chk("err", {31'b0, err}, {31'b0, m_err});
    chk("addr", mad, m_addr);
    chk("count", cnt, m_cnt[31:0]);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic idle();
    stall = 0; ready = 0; redir = 0; trap = 0;
    halt = 0; resume = 0; rpc = 0; tbase = 0;
  endtask

  typedef struct {
    logic        stall, ready, redir;
    logic [31:0] rpc;
    logic        trap;
    logic [31:0] tbase;
    logic        halt, resume;
    logic [31:0] e_pc;
    logic [1:0]  e_st;
    logic        e_err;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{0,1,0,0,0,0,0,0, 32'h100, 2'd0, 0, 0};
    tbl[1]  = '{0,1,0,0,0,0,0,0, 32'h100, 2'd1, 0, 0};
    tbl[2]  = '{0,1,0,0,0,0,0,0, 32'h104, 2'd1, 0, 1};
    tbl[3]  = '{0,1,0,0,0,0,0,0, 32'h108, 2'd1, 0, 2};
    tbl[4]  = '{0,1,0,0,0,0,0,0, 32'h10C, 2'd1, 0, 3};
    tbl[5]  = '{0,1,1,32'h200,0,0,0,0, 32'h200, 2'd1, 0, 4};
    tbl[6]  = '{0,0,0,0,0,0,0,0, 32'h200, 2'd1, 0, 4};
    tbl[7]  = '{0,0,0,0,0,0,0,0, 32'h200, 2'd1, 0, 4};
    tbl[8]  = '{0,0,0,0,0,0,0,0, 32'h200, 2'd1, 0, 4};
    tbl[9]  = '{0,1,0,0,0,0,0,0, 32'h204, 2'd1, 0, 5};
    tbl[10] = '{0,1,1,32'h400,1,32'h8003,0,0, 32'h8000, 2'd1, 0, 6};
    tbl[11] = '{0,1,1,32'h402,0,32'h8003,0,0, 32'h8000, 2'd1, 1, 7};
    tbl[12] = '{0,0,0,0,0,32'h8003,0,0, 32'h8000, 2'd1, 0, 7};

    idle();
    ready = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, RV);
    chk("rst_state", {30'b0, st}, 0);
    chk("rst_valid", {31'b0, val}, 0);
    chk("rst_count", cnt, 0);
    chk("rst_err", {31'b0, err}, 0);
    chk("rst_addr", mad, 0);
    rst_n = 1;

    for (int i = 0; i < 13; i++) begin
      stall  = tbl[i].stall;
      ready  = tbl[i].ready;
      redir  = tbl[i].redir;
      rpc    = tbl[i].rpc;
      trap   = tbl[i].trap;
      tbase  = tbl[i].tbase;
      halt   = tbl[i].halt;
      resume = tbl[i].resume;
      tick();
      chk($sformatf("v%0d_pc", i), pc, tbl[i].e_pc);
      chk($sformatf("v%0d_st", i), {30'b0, st}, {30'b0, tbl[i].e_st});
      chk($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, tbl[i].e_err});
      chk($sformatf("v%0d_cnt", i), cnt, tbl[i].e_cnt);
      if (i == 11) begin
        chk("a16_pc", pc16, 32'h402);
        chk("a16_err", {31'b0, err16}, 0);
        chk("misalign_addr", mad, 32'h402);
      end
    end

    // halt with a fire in the same cycle, then frozen for 10 cycles
    idle();
    ready = 1;
    halt  = 1;
    tick();
    chk("halt_st", {30'b0, st}, 2);
    chk("halt_pc", pc, 32'h8004);
    chk("halt_cnt", cnt, 8);
    halt  = 0;
    redir = 1;
    rpc   = 32'h300;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("frz_pc", pc, 32'h8004);
      chk("frz_valid", {31'b0, val}, 0);
    end
    redir  = 0;
    halt   = 1;
    resume = 1;
    tick();
    chk("resume_st", {30'b0, st}, 1);
    halt   = 0;
    resume = 0;
    tick();
    chk("resume_pc", pc, 32'h8008);

    // wrap at top of address space
    idle();
    redir = 1;
    rpc   = 32'hFFFF_FFFC;
    tick();
    chk("top_pc", pc, 32'hFFFF_FFFC);
    redir = 0;
    ready = 1;
    tick();
    chk("wrap_pc", pc, 32'h0);

    // counter saturation from a preloaded value
    dut.cnt_q = 32'hFFFF_FFFD;
    m_cnt = 64'hFFFF_FFFD;
    repeat (4) tick();
    chk("sat_cnt", cnt, 32'hFFFF_FFFF);

    // random traffic with an asynchronous reset in the middle
    for (int i = 0; i < 1500; i++) begin
      stall  = ($urandom_range(0, 3) == 0);
      ready  = ($urandom_range(0, 3) != 0);
      redir  = ($urandom_range(0, 7) == 0);
      rpc    = $urandom;
      if ($urandom_range(0, 1) == 0) rpc[1:0] = 2'b00;
      trap   = ($urandom_range(0, 15) == 0);
      tbase  = $urandom;
      halt   = ($urandom_range(0, 15) == 0);
      resume = ($urandom_range(0, 3) == 0);
      if (i == 700) begin
        #2;
        rst_n = 0;
        #1;
        chk("mid_rst_pc", pc, RV);
        chk("mid_rst_state", {30'b0, st}, 0);
        chk("mid_rst_valid", {31'b0, val}, 0);
        chk("mid_rst_count", cnt, 0);
        chk("mid_rst_err", {31'b0, err}, 0);
        chk("mid_rst_addr", mad, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
      end else begin
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
